digest_unpacker: RTL and testbench
==================================

Name: digest_unpacker

Overview:
- Consumer end of the wide digest stream: accepts one 512-bit big-endian hash beat with byte-enable tkeep, covering SHA224/256/384/512.
- Serialises the valid bytes into 32-bit words on a narrow AXI-Stream master, for the host register, UART and PCIe readback paths.
- Asserts tlast on the final word of each digest; keeps a sticky error flag and a completed-digest counter.

Parameters:
- S_AXIS_DATA_WIDTH, 512, width of incoming digest beat; must be a multiple of 32.
- M_AXIS_DATA_WIDTH, 32, output word width; fixed at 32.
- COUNT_WIDTH, 16, width of digest_count.

Ports:
- axi_aclk  in  1  clock
- axi_resetn  in  1  synchronous active-low reset
- s_axis_tdata  in  S_AXIS_DATA_WIDTH  digest; word i at bits [32i+31:32i], word 0 = H0
- s_axis_tkeep  in  S_AXIS_DATA_WIDTH/8  byte enables
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  ready; high only in IDLE
- s_axis_tlast  in  1  ignored; every beat is a complete digest
- m_axis_tdata  out  32  current output word
- m_axis_tkeep  out  4  always 4'hF while m_axis_tvalid
- m_axis_tvalid  out  1  word valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last word of digest
- err_clear  in  1  clears bad_keep
- bad_keep  out  1  sticky: malformed tkeep seen
- digest_count  out  COUNT_WIDTH  completed digests, wraps

Behaviour:
- Reset (axi_resetn=0 at posedge):
  - s_axis_tready=1; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0.
  - bad_keep=0, digest_count=0; internal buffer, index and word count cleared.
  - State → IDLE. Reset mid-SEND abandons the digest with no completion counted.
- FSM states: IDLE, SEND.
- IDLE, s_axis_tvalid & s_axis_tready:
  - tkeep is valid only if it equals 2^(4k)-1 with 1 ≤ k ≤ S_AXIS_DATA_WIDTH/32: contiguous from bit 0 and a whole number of words.
  - Valid tkeep: latch tdata into the buffer and set nwords=k. Next cycle: state=SEND, s_axis_tready=0, m_axis_tvalid=1, m_axis_tdata=word 0, m_axis_tkeep=4'hF, m_axis_tlast=(k==1).
  - Invalid tkeep: discard the beat, bad_keep←1, stay in IDLE with s_axis_tready=1.
- SEND:
  - On m_axis_tvalid & m_axis_tready with idx < nwords-1: idx←idx+1, m_axis_tdata←word idx+1, m_axis_tlast←(idx+1 == nwords-1).
  - On the handshake with m_axis_tlast=1: m_axis_tvalid←0, m_axis_tlast←0, digest_count←digest_count+1 (modulo 2^COUNT_WIDTH), s_axis_tready←1, state←IDLE.
  - Stall (m_axis_tready=0): m_axis_tdata, m_axis_tlast and m_axis_tvalid hold stable. m_axis_tvalid never drops without a handshake.
- Latency and throughput:
  - First word is valid 1 cycle after input accept.
  - 1 word/cycle under continuous m_axis_tready.
  - Mandatory 1-cycle s_axis_tready bubble after the last word; no overlap of digests.
- Word counts per sha_type at the digest producer: SHA224=7, SHA256=8, SHA384=12, SHA512=16. Bytes above the tkeep boundary are never emitted.
- Byte order: each 32-bit lane is passed through unchanged. The producer has already applied big-endian conversion; this block performs no byte swap.
- err_clear:
  - bad_keep←0 the cycle after err_clear=1.
  - Simultaneous err_clear and a new malformed beat: set wins, bad_keep=1.
- digest_count wraps from 2^COUNT_WIDTH-1 to 0 without a flag.
- s_axis_tvalid asserted in SEND is ignored. The upstream beat holds until IDLE, as AXIS requires.

Test Plan:
- SHA256 beat, word i=32'h1000_0000+i, tkeep=64'h0000_0000_FFFF_FFFF, m_axis_tready=1 → 8 words 1000_0000..1000_0007 on consecutive cycles; tlast on the 8th only; s_axis_tready=1 one cycle later; digest_count=1.
- SHA224, tkeep=64'h0000_0000_0FFF_FFFF → 7 words; tlast on word 6; word 7 of tdata never appears.
- SHA512, tkeep all ones, m_axis_tready toggling 1,0,0,1,… → 16 words in order; tdata and tlast stable through every stall; no word duplicated or lost.
- Malformed tkeep 64'h0000_0000_0000_00FE, then 64'h0000_0000_0000_003F → no m_axis_tvalid, bad_keep=1, s_axis_tready stays 1; err_clear pulse → bad_keep=0 next cycle.
- SHA384 (12 words), axi_resetn=0 for 1 cycle after the 3rd word handshake → next cycle m_axis_tvalid=0, s_axis_tready=1, digest_count=0; a following SHA256 beat emits all 8 words correctly.
- digest_count preloaded to 16'hFFFF via 65535 SHA224 digests, or forced in sim; one more digest → digest_count=0.

Source files
------------

// File: rtl/digest_unpacker.sv
// digest_unpacker: serialises one wide big-endian digest beat into 32-bit AXI-Stream words.
// Revision: 1.0
`default_nettype none

module digest_unpacker #(
  parameter int S_AXIS_DATA_WIDTH = 512,
  parameter int M_AXIS_DATA_WIDTH = 32,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                           axi_aclk,
  input  logic                           axi_resetn,
  input  logic [S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [3:0]                     m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  input  logic                           err_clear,
  output logic                           bad_keep,
  output logic [COUNT_WIDTH-1:0]         digest_count
);

  localparam int NW  = S_AXIS_DATA_WIDTH / 32;
  localparam int KW  = S_AXIS_DATA_WIDTH / 8;
  localparam int IW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int NWW = $clog2(NW + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [S_AXIS_DATA_WIDTH-1:0] buf_q, buf_d;
  logic [NWW-1:0]               nwords_q, nwords_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [31:0]                  tdata_q, tdata_d;
  logic                         tlast_q, tlast_d;
  logic                         tvalid_q, tvalid_d;
  logic                         bad_q, bad_d;
  logic [COUNT_WIDTH-1:0]       count_q, count_d;

  logic                         w_keep_ok;
  logic [NWW-1:0]               w_k;
  logic [IW-1:0]                w_next_idx;
  logic [31:0]                  w_words [NW];
  logic                         w_unused;

  // Every beat is a whole digest, so tlast from upstream carries no information.
  assign w_unused = s_axis_tlast;

  for (genvar g = 0; g < NW; g++) begin : g_words
    assign w_words[g] = buf_q[32*g +: 32];
  end

  // tkeep must be exactly k whole words packed from bit 0.
  always_comb begin
    logic [KW-1:0] mask;
    mask      = '0;
    w_keep_ok = 1'b0;
    w_k       = '0;
    for (int k = 1; k <= NW; k++) begin
      mask = (mask << 4) | KW'(4'hF);
      if (s_axis_tkeep == mask) begin
        w_keep_ok = 1'b1;
        w_k       = NWW'(k);
      end
    end
  end

  assign w_next_idx = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    nwords_d = nwords_q;
    idx_d    = idx_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    count_d  = count_q;
    bad_d    = err_clear ? 1'b0 : bad_q;
    case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid) begin
          if (w_keep_ok) begin
            buf_d    = s_axis_tdata;
            nwords_d = w_k;
            idx_d    = '0;
            tdata_d  = s_axis_tdata[31:0];
            tlast_d  = (w_k == NWW'(1));
            tvalid_d = 1'b1;
            state_d  = S_SEND;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            count_d  = count_q + 1'b1;
            state_d  = S_IDLE;
          end else begin
            idx_d   = w_next_idx;
            tdata_d = w_words[w_next_idx];
            tlast_d = (NWW'(w_next_idx) == nwords_q - 1'b1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      nwords_q <= '0;
      idx_q    <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      bad_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      nwords_q <= nwords_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      bad_q    <= bad_d;
      count_q  <= count_d;
    end
  end

  assign s_axis_tready = (state_q == S_IDLE);
  assign m_axis_tdata  = M_AXIS_DATA_WIDTH'(tdata_q);
  assign m_axis_tkeep  = tvalid_q ? 4'hF : 4'h0;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign bad_keep      = bad_q;
  assign digest_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_digest_unpacker.sv
// tb_digest_unpacker: directed-vector bench for digest_unpacker.
// Revision: 1.0
`default_nettype none

module tb_digest_unpacker;

  // Narrow counter so the wrap boundary is reachable in a few digests.
  localparam int CW = 4;

  logic          clk;
  logic          resetn;
  logic [511:0]  s_tdata;
  logic [63:0]   s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [31:0]   m_tdata;
  logic [3:0]    m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          err_clear;
  logic          bad_keep;
  logic [CW-1:0] digest_count;

  int checks;
  int failures;

  digest_unpacker #(
    .S_AXIS_DATA_WIDTH(512),
    .M_AXIS_DATA_WIDTH(32),
    .COUNT_WIDTH(CW)
  ) dut (
    .axi_aclk     (clk),
    .axi_resetn   (resetn),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .err_clear    (err_clear),
    .bad_keep     (bad_keep),
    .digest_count (digest_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mk_beat(input logic [31:0] base);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  // Starts and ends at a negedge; on return the first output word is visible.
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k);
    s_tdata  = d;
    s_tkeep  = k;
    s_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  // mode 0: ready every cycle; mode 1: ready pattern 1,0,0 repeating.
  task automatic recv(input int n, input logic [31:0] base, input int mode);
    int  i;
    int  p;
    int  cyc;
    logic rdy;
    i = 0; p = 0; cyc = 0;
    while (i < n && cyc < 200) begin
      check("m_valid", 64'(m_tvalid), 64'd1);
      check("m_data", 64'(m_tdata), 64'(base + 32'(i)));
      check("m_last", 64'(m_tlast), 64'(i == n - 1));
      check("m_keep", 64'(m_tkeep), 64'hF);
      check("s_ready_busy", 64'(s_tready), 64'd0);
      rdy = (mode == 0) ? 1'b1 : (p % 3 == 0);
      p++;
      m_tready = rdy;
      if (rdy) i++;
      cyc++;
      @(negedge clk);
    end
    if (i < n) check("recv_timeout", 64'd0, 64'd1);
    m_tready = 1'b1;
  endtask

  task automatic check_idle(input string tag, input logic [CW-1:0] exp_cnt);
    check({tag, "_m_valid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_s_ready"}, 64'(s_tready), 64'd1);
    check({tag, "_count"}, 64'(digest_count), 64'(exp_cnt));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    resetn    = 1'b0;
    s_tdata   = '0;
    s_tkeep   = '0;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    m_tready  = 1'b1;
    err_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 64'(s_tready), 64'd1);
    check("rst_m_valid", 64'(m_tvalid), 64'd0);
    check("rst_m_last", 64'(m_tlast), 64'd0);
    check("rst_m_data", 64'(m_tdata), 64'd0);
    check("rst_m_keep", 64'(m_tkeep), 64'd0);
    check("rst_bad", 64'(bad_keep), 64'd0);
    check("rst_count", 64'(digest_count), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // SHA256: 8 words back to back
    send_beat(mk_beat(32'h1000_0000), 64'h0000_0000_FFFF_FFFF);
    recv(8, 32'h1000_0000, 0);
    check_idle("sha256", 4'd1);

    // SHA224: 7 words, word 7 never emitted
    send_beat(mk_beat(32'h2000_0000), 64'h0000_0000_0FFF_FFFF);
    recv(7, 32'h2000_0000, 0);
    check_idle("sha224", 4'd2);

    // SHA512 with downstream stalls
    send_beat(mk_beat(32'h3000_0000), 64'hFFFF_FFFF_FFFF_FFFF);
    recv(16, 32'h3000_0000, 1);
    check_idle("sha512", 4'd3);

    // Malformed tkeep: non-contiguous, then partial word
    send_beat(mk_beat(32'h6000_0000), 64'h0000_0000_0000_00FE);
    check("bad1_m_valid", 64'(m_tvalid), 64'd0);
    check("bad1_flag", 64'(bad_keep), 64'd1);
    check("bad1_s_ready", 64'(s_tready), 64'd1);
    send_beat(mk_beat(32'h6000_0000), 64'h0000_0000_0000_003F);
    check("bad2_m_valid", 64'(m_tvalid), 64'd0);
    check("bad2_flag", 64'(bad_keep), 64'd1);
    check("bad2_s_ready", 64'(s_tready), 64'd1);
    err_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clear = 1'b0;
    check("clr_flag", 64'(bad_keep), 64'd0);
    // Clear and a new malformed beat together: set wins
    err_clear = 1'b1;
    send_beat(mk_beat(32'h6000_0000), 64'h0000_0000_0000_0001);
    err_clear = 1'b0;
    check("set_wins_flag", 64'(bad_keep), 64'd1);
    check("set_wins_m_valid", 64'(m_tvalid), 64'd0);
    err_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clear = 1'b0;
    check("clr2_flag", 64'(bad_keep), 64'd0);
    check("bad_count", 64'(digest_count), 64'd3);

    // SHA384 abandoned by reset after the third word
    send_beat(mk_beat(32'h4000_0000), 64'h0000_FFFF_FFFF_FFFF);
    for (int j = 0; j < 3; j++) begin
      check("s384_data", 64'(m_tdata), 64'(32'h4000_0000 + 32'(j)));
      check("s384_last", 64'(m_tlast), 64'd0);
      m_tready = 1'b1;
      @(negedge clk);
    end
    check("s384_word3", 64'(m_tdata), 64'h4000_0003);
    resetn   = 1'b0;
    m_tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn   = 1'b1;
    m_tready = 1'b1;
    check_idle("midrst", 4'd0);
    send_beat(mk_beat(32'h5000_0000), 64'h0000_0000_FFFF_FFFF);
    recv(8, 32'h5000_0000, 0);
    check_idle("post_rst", 4'd1);

    // Single-word digests up to the counter wrap
    for (int d = 0; d < 14; d++) begin
      send_beat(mk_beat(32'h7000_0000 + 32'(d << 8)), 64'h0000_0000_0000_000F);
      recv(1, 32'h7000_0000 + 32'(d << 8), 0);
    end
    check_idle("pre_wrap", 4'd15);
    send_beat(mk_beat(32'h8000_0000), 64'h0000_0000_0000_000F);
    recv(1, 32'h8000_0000, 0);
    check_idle("wrap", 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
